// File: rtl/scope_pkg.sv
// Shared scope definitions: capture buffer geometry, dump sync byte and dump sequencer states.
package scope_pkg;

    localparam int         BUFFER_LEN = 512;
    localparam int         ADDR_W     = 9;
    localparam logic [7:0] HEADER     = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        SAMPLE,
        DONE
    } dump_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 transmitter. A new byte may be loaded on the last cycle of the stop bit,
// so consecutive frames run back-to-back with no idle time.
module uart_tx
    import scope_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       pll_clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_frame_end
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt_q;
    logic [3:0]    bit_idx_q;
    logic [8:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          bit_end;

    assign bit_end     = busy_q && (clk_cnt_q == CLK_LAST);
    assign o_frame_end = bit_end && (bit_idx_q == 4'd9);
    assign o_tx        = tx_q;
    assign o_busy      = busy_q;

    // shift_q holds the remaining data bits with the stop bit parked in the MSB.
    always_ff @(posedge pll_clk or posedge rst) begin
        if (rst) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else if (i_load && (!busy_q || o_frame_end)) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= {1'b1, i_byte};
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 4'd9) begin
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                tx_q      <= shift_q[0];
                shift_q   <= {1'b1, shift_q[8:1]};
                bit_idx_q <= bit_idx_q + 4'd1;
            end
        end else if (busy_q) begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/capture_uart_dump.sv
// Streams one capture buffer (sync header then every sample, oldest first) out over UART,
// prefetching each sample from the sample RAM while the previous frame is on the wire.
module capture_uart_dump #(
    parameter int         BUFFER_LEN   = scope_pkg::BUFFER_LEN,
    parameter int         ADDR_W       = scope_pkg::ADDR_W,
    parameter int         CLKS_PER_BIT = 234,
    parameter logic [7:0] HEADER       = scope_pkg::HEADER
) (
    input  logic              pll_clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_start_addr,
    output logic              o_ram_ce,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [7:0]        i_ram_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_tx
);

    import scope_pkg::*;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(BUFFER_LEN - 1);
    localparam logic [ADDR_W:0] NUM_IDX  = (ADDR_W + 1)'(BUFFER_LEN);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [7:0]        hold_q;
    logic              ram_ce_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              rd_pend_q;
    logic              abort_q;

    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic              frame_end;
    logic              tx_ready;
    logic              abort_now;
    logic [ADDR_W:0]   rd_idx;
    logic              rd_issue;

    assign tx_ready   = !tx_busy || frame_end;
    assign abort_now  = abort_q || i_abort;
    assign o_busy     = (state_q == HDR) || (state_q == SAMPLE);
    assign o_done     = (state_q == DONE);
    assign o_ram_ce   = ram_ce_q;
    assign o_ram_addr = ram_addr_q;

    // count_q is the index of the sample on the wire; the next read runs one sample ahead of it.
    always_comb begin
        state_d  = state_q;
        tx_load  = 1'b0;
        tx_byte  = hold_q;
        rd_idx   = (state_q == HDR) ? count_q + (ADDR_W + 1)'(1) : count_q + (ADDR_W + 1)'(2);
        rd_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && tx_ready) begin
                    state_d = HDR;
                    tx_load = 1'b1;
                    tx_byte = HEADER;
                end
            end
            HDR: begin
                if (frame_end) begin
                    if (abort_now) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SAMPLE;
                        tx_load = 1'b1;
                    end
                end
            end
            SAMPLE: begin
                if (frame_end) begin
                    if (abort_now) begin
                        state_d = IDLE;
                    end else if (count_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        tx_load = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rd_issue = tx_load && (state_q != IDLE) && (rd_idx < NUM_IDX);
    end

    always_ff @(posedge pll_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            ram_ce_q   <= 1'b0;
            ram_addr_q <= '0;
            rd_pend_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ram_ce_q  <= 1'b0;
            rd_pend_q <= ram_ce_q;
            if (rd_pend_q) begin
                hold_q <= i_ram_data;
            end
            if (o_busy && i_abort) begin
                abort_q <= 1'b1;
            end
            if (state_q == IDLE && state_d == HDR) begin
                base_q     <= i_start_addr;
                count_q    <= '0;
                abort_q    <= 1'b0;
                ram_ce_q   <= 1'b1;
                ram_addr_q <= i_start_addr;
            end
            if (rd_issue) begin
                ram_ce_q   <= 1'b1;
                ram_addr_q <= base_q + rd_idx[ADDR_W-1:0];
            end
            if (state_q == SAMPLE && tx_load) begin
                count_q <= count_q + (ADDR_W + 1)'(1);
            end
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .pll_clk     (pll_clk),
        .rst         (rst),
        .i_load      (tx_load),
        .i_byte      (tx_byte),
        .o_tx        (o_tx),
        .o_busy      (tx_busy),
        .o_frame_end (frame_end)
    );

endmodule
